// File: rtl/interface_mux_arbiter.sv
// N-to-1 frame multiplexer: per-frame strict-priority / round-robin arbitration over rx
// pointer FIFOs, then forwards the granted port's data reads until the frame length is consumed.
module interface_mux_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int PTR_W  = 16,
    parameter int LEN_W  = 12,
    parameter int PRIO_W = 2,
    parameter int SRC_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*PRIO_W-1:0]  prio_cfg,
    input  logic [NUM_IN-1:0]         rx_ptr_fifo_empty,
    input  logic [NUM_IN*PTR_W-1:0]   rx_ptr_fifo_dout,
    output logic [NUM_IN-1:0]         rx_ptr_fifo_rd,
    input  logic [NUM_IN*DATA_W-1:0]  rx_data_fifo_dout,
    output logic [NUM_IN-1:0]         rx_data_fifo_rd,
    output logic                      sw_ptr_fifo_empty,
    output logic [SRC_W+PTR_W-1:0]    sw_ptr_fifo_dout,
    input  logic                      sw_ptr_fifo_rd,
    output logic [DATA_W-1:0]         sw_data_fifo_dout,
    input  logic                      sw_data_fifo_rd,
    output logic                      busy,
    output logic [SRC_W-1:0]          grant_src
);

    typedef enum logic [1:0] {
        IDLE,
        PTR_RDY,
        XFER
    } state_t;

    state_t            state;
    logic [SRC_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  ptr_hold;
    logic [LEN_W-1:0]  byte_cnt;

    logic [NUM_IN-1:0] req;
    logic              any_req;
    logic [PRIO_W-1:0] top_prio;
    logic [SRC_W-1:0]  win;
    logic [SRC_W-1:0]  rr_next;
    logic [LEN_W-1:0]  frame_len;

    logic [PRIO_W-1:0] prio     [NUM_IN];
    logic [PTR_W-1:0]  ptr_word [NUM_IN];
    logic [DATA_W-1:0] data_word[NUM_IN];

    always_comb begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            prio[i]      = prio_cfg[i*PRIO_W +: PRIO_W];
            ptr_word[i]  = rx_ptr_fifo_dout[i*PTR_W +: PTR_W];
            data_word[i] = rx_data_fifo_dout[i*DATA_W +: DATA_W];
        end
    end

    assign req       = ~rx_ptr_fifo_empty;
    assign any_req   = |req;
    assign frame_len = ptr_hold[LEN_W-1:0];

    // Two passes: find the highest requesting level, then the first requester at
    // that level scanning upward from rr_ptr with wrap at NUM_IN.
    always_comb begin
        logic [SRC_W:0]   sum;
        logic [SRC_W-1:0] idx;
        logic             found;
        logic [SRC_W:0]   nxt;
        top_prio = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (req[i] && (prio[i] > top_prio)) begin
                top_prio = prio[i];
            end
        end
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (sum >= (SRC_W+1)'(NUM_IN)) begin
                sum = sum - (SRC_W+1)'(NUM_IN);
            end
            idx = sum[SRC_W-1:0];
            if (!found && req[idx] && (prio[idx] == top_prio)) begin
                win   = idx;
                found = 1'b1;
            end
        end
        nxt = {1'b0, win} + (SRC_W+1)'(1);
        if (nxt >= (SRC_W+1)'(NUM_IN)) begin
            rr_next = '0;
        end else begin
            rr_next = nxt[SRC_W-1:0];
        end
    end

    always_comb begin
        rx_ptr_fifo_rd  = '0;
        rx_data_fifo_rd = '0;
        if (!rst && (state == IDLE) && any_req) begin
            rx_ptr_fifo_rd[win] = 1'b1;
        end
        if (!rst && (state == XFER) && sw_data_fifo_rd) begin
            rx_data_fifo_rd[grant_src] = 1'b1;
        end
    end

    assign busy              = (state != IDLE);
    assign sw_ptr_fifo_empty = (state != PTR_RDY);
    assign sw_ptr_fifo_dout  = {grant_src, ptr_hold};
    assign sw_data_fifo_dout = data_word[grant_src];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            ptr_hold  <= '0;
            grant_src <= '0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        ptr_hold  <= ptr_word[win];
                        grant_src <= win;
                        rr_ptr    <= rr_next;
                        state     <= PTR_RDY;
                    end
                end
                PTR_RDY: begin
                    if (sw_ptr_fifo_rd) begin
                        byte_cnt <= '0;
                        state    <= (frame_len == '0) ? IDLE : XFER;
                    end
                end
                XFER: begin
                    if (sw_data_fifo_rd) begin
                        byte_cnt <= byte_cnt + LEN_W'(1);
                        if (byte_cnt == frame_len - LEN_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interface_mux_arbiter.sv
// Bench for interface_mux_arbiter: rx FIFOs and a transaction-level reference model
// are kept as queues; every cycle the DUT outputs are compared with the model.
module tb_interface_mux_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int PW = 16;
    localparam int LW = 12;
    localparam int QW = 2;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N*QW-1:0]   prio_cfg;
    logic [N-1:0]      rx_ptr_fifo_empty;
    logic [N*PW-1:0]   rx_ptr_fifo_dout;
    logic [N-1:0]      rx_ptr_fifo_rd;
    logic [N*DW-1:0]   rx_data_fifo_dout;
    logic [N-1:0]      rx_data_fifo_rd;
    logic              sw_ptr_fifo_empty;
    logic [SW+PW-1:0]  sw_ptr_fifo_dout;
    logic              sw_ptr_fifo_rd;
    logic [DW-1:0]     sw_data_fifo_dout;
    logic              sw_data_fifo_rd;
    logic              busy;
    logic [SW-1:0]     grant_src;

    interface_mux_arbiter #(
        .NUM_IN(N), .DATA_W(DW), .PTR_W(PW), .LEN_W(LW), .PRIO_W(QW), .SRC_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .prio_cfg(prio_cfg),
        .rx_ptr_fifo_empty(rx_ptr_fifo_empty), .rx_ptr_fifo_dout(rx_ptr_fifo_dout),
        .rx_ptr_fifo_rd(rx_ptr_fifo_rd), .rx_data_fifo_dout(rx_data_fifo_dout),
        .rx_data_fifo_rd(rx_data_fifo_rd), .sw_ptr_fifo_empty(sw_ptr_fifo_empty),
        .sw_ptr_fifo_dout(sw_ptr_fifo_dout), .sw_ptr_fifo_rd(sw_ptr_fifo_rd),
        .sw_data_fifo_dout(sw_data_fifo_dout), .sw_data_fifo_rd(sw_data_fifo_rd),
        .busy(busy), .grant_src(grant_src)
    );

    logic [PW-1:0] pq [N][$];
    logic [DW-1:0] dq [N][$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model: phase 0 = waiting for a frame, 1 = pointer offered, 2 = data phase
    int            m_phase, m_rr, m_grant, m_left, pick;
    logic [PW-1:0] m_ptr;
    logic [N-1:0]  exp_ptr_rd, exp_data_rd;
    int            order[$];
    int            exp_rr[6]   = '{0, 1, 2, 3, 0, 1};
    int            exp_prio[8] = '{2, 2, 3, 0, 1, 3, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int p, input int len, input logic [3:0] flags, input logic [7:0] base);
        pq[p].push_back({flags, LW'(len)});
        for (int k = 0; k < len; k++) dq[p].push_back(base + 8'(k));
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (pq[i].size() != 0 || dq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Winner = largest (priority, closeness to rr in cyclic order) among non-empty ports.
    function automatic int model_pick();
        int best = -1;
        int best_key = -1;
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() != 0) begin
                int key;
                key = int'(prio_cfg[i*QW +: QW]) * N + (N - 1 - ((i - m_rr + N) % N));
                if (key > best_key) begin
                    best_key = key;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic drop(input int p, input int n);
        for (int k = 0; k < n && dq[p].size() > 0; k++) void'(dq[p].pop_front());
    endtask

    // Drive FIFO heads, then compare DUT outputs against the model for this cycle.
    task automatic pre();
        for (int i = 0; i < N; i++) begin
            rx_ptr_fifo_empty[i] = (pq[i].size() == 0);
            rx_ptr_fifo_dout[i*PW +: PW] = (pq[i].size() != 0) ? pq[i][0] : '0;
            rx_data_fifo_dout[i*DW +: DW] = (dq[i].size() != 0) ? dq[i][0] : 8'hEE;
        end
        #1;
        pick = model_pick();
        exp_ptr_rd = '0;
        if (!rst && m_phase == 0 && pick >= 0) exp_ptr_rd[pick] = 1'b1;
        exp_data_rd = '0;
        if (!rst && m_phase == 2 && sw_data_fifo_rd) exp_data_rd[m_grant] = 1'b1;
        chk("busy", busy, m_phase != 0);
        chk("sw_ptr_empty", sw_ptr_fifo_empty, m_phase != 1);
        chk("grant_src", grant_src, m_grant);
        chk("rx_ptr_rd", rx_ptr_fifo_rd, exp_ptr_rd);
        chk("rx_data_rd", rx_data_fifo_rd, exp_data_rd);
        chk("sw_data_dout", sw_data_fifo_dout, rx_data_fifo_dout[m_grant*DW +: DW]);
        if (m_phase == 1) chk("sw_ptr_dout", sw_ptr_fifo_dout, {SW'(m_grant), m_ptr});
    endtask

    // Advance the model and the rx FIFOs by one clock, then move to the next drive point.
    task automatic post();
        if (rst) begin
            if (m_phase == 1) drop(m_grant, int'(m_ptr[LW-1:0]));
            else if (m_phase == 2) drop(m_grant, m_left);
            m_phase = 0; m_rr = 0; m_grant = 0; m_left = 0; m_ptr = '0;
        end else begin
            case (m_phase)
                0: if (pick >= 0) begin
                    m_ptr = pq[pick].pop_front();
                    m_grant = pick;
                    m_rr = (pick + 1) % N;
                    m_phase = 1;
                end
                1: if (sw_ptr_fifo_rd) begin
                    m_left = int'(m_ptr[LW-1:0]);
                    m_phase = (m_left == 0) ? 0 : 2;
                end
                2: if (sw_data_fifo_rd) begin
                    void'(dq[m_grant].pop_front());
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            pq[i].delete();
            dq[i].delete();
        end
        rst = 1'b1;
        pre();
        post();
        rst = 1'b0;
    endtask

    task automatic run_frames(input int max_cycles);
        order.delete();
        for (int c = 0; c < max_cycles; c++) begin
            if (m_phase == 0 && all_empty()) break;
            pre();
            for (int i = 0; i < N; i++) if (rx_ptr_fifo_rd[i]) order.push_back(i);
            post();
        end
        chk("drain_done", (m_phase == 0) && all_empty(), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; prio_cfg = '0; sw_ptr_fifo_rd = 1'b0; sw_data_fifo_rd = 1'b0;
        rx_ptr_fifo_empty = '1; rx_ptr_fifo_dout = '0; rx_data_fifo_dout = '0;
        m_phase = 0; m_rr = 0; m_grant = 0; m_left = 0; m_ptr = '0; pick = -1;
        @(negedge clk);
        do_reset();

        pre();
        chk("rst_busy", busy, 1'b0);
        chk("rst_empty", sw_ptr_fifo_empty, 1'b1);
        chk("rst_grant", grant_src, 2'd0);
        post();

        // Single frame on port 1
        push_frame(1, 4, 4'h0, 8'hA0);
        pre(); chk("t1_ptr_rd", rx_ptr_fifo_rd, 4'b0010); post();
        sw_ptr_fifo_rd = 1'b1;
        pre(); chk("t1_empty", sw_ptr_fifo_empty, 1'b0); chk("t1_dout", sw_ptr_fifo_dout, 18'h10004); post();
        sw_ptr_fifo_rd = 1'b0; sw_data_fifo_rd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pre();
            chk("t1_data", sw_data_fifo_dout, 8'hA0 + 8'(k));
            chk("t1_drd", rx_data_fifo_rd, 4'b0010);
            post();
        end
        sw_data_fifo_rd = 1'b0;
        pre(); chk("t1_idle", busy, 1'b0); chk("t1_norx", rx_data_fifo_rd, 4'b0000); post();

        // Equal priority round robin from reset
        do_reset();
        for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) push_frame(p, 2, 4'h5, 8'(p * 16 + r * 4));
        sw_ptr_fifo_rd = 1'b1; sw_data_fifo_rd = 1'b1;
        run_frames(80);
        chk("t2_count", order.size(), 8);
        for (int k = 0; k < 6; k++) chk("t2_order", (order.size() > k) ? order[k] : -1, exp_rr[k]);

        // Port 2 at top priority, then round robin resumes from rr=3
        do_reset();
        prio_cfg = 8'h30;
        for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) push_frame(p, 1, 4'h0, 8'(p + r * 8));
        run_frames(80);
        chk("t3_count", order.size(), 8);
        for (int k = 0; k < 8; k++) chk("t3_order", (order.size() > k) ? order[k] : -1, exp_prio[k]);
        prio_cfg = '0;

        // Zero-length frame on port 3, then stray reads while idle
        do_reset();
        push_frame(3, 0, 4'h0, 8'h00);
        sw_ptr_fifo_rd = 1'b0;
        pre(); chk("t4_ptr_rd", rx_ptr_fifo_rd, 4'b1000); post();
        sw_ptr_fifo_rd = 1'b1;
        pre(); chk("t4_dout", sw_ptr_fifo_dout, 18'h30000); post();
        for (int k = 0; k < 3; k++) begin
            pre();
            chk("t4_idle", busy, 1'b0);
            chk("t4_nodata", rx_data_fifo_rd, 4'b0000);
            chk("t4_noptr", rx_ptr_fifo_rd, 4'b0000);
            post();
        end

        // Data reads while the pointer is still offered are ignored
        push_frame(1, 2, 4'h0, 8'h40);
        sw_ptr_fifo_rd = 1'b0;
        pre(); post();
        for (int k = 0; k < 3; k++) begin
            pre();
            chk("t5_hold", sw_ptr_fifo_empty, 1'b0);
            chk("t5_nodata", rx_data_fifo_rd, 4'b0000);
            post();
        end
        sw_ptr_fifo_rd = 1'b1;
        run_frames(20);

        // Reset in the middle of an 8-byte frame
        do_reset();
        push_frame(0, 8, 4'h0, 8'h10);
        for (int k = 0; k < 4; k++) begin pre(); post(); end
        rst = 1'b1;
        pre(); chk("t6_rst_rd", rx_data_fifo_rd, 4'b0000); post();
        rst = 1'b0;
        push_frame(3, 1, 4'h0, 8'h33);
        push_frame(0, 1, 4'h0, 8'h00);
        pre();
        chk("t6_busy", busy, 1'b0);
        chk("t6_empty", sw_ptr_fifo_empty, 1'b1);
        chk("t6_rr0", rx_ptr_fifo_rd, 4'b0001);
        post();
        run_frames(40);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            sw_ptr_fifo_rd  = ($urandom_range(0, 1) == 0);
            sw_data_fifo_rd = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) prio_cfg = 8'($urandom);
            for (int p = 0; p < N; p++)
                if (pq[p].size() < 3 && $urandom_range(0, 9) == 0)
                    push_frame(p, $urandom_range(0, 6), 4'($urandom), 8'($urandom));
            pre();
            post();
        end
        rst = 1'b0;
        sw_ptr_fifo_rd = 1'b1; sw_data_fifo_rd = 1'b1;
        run_frames(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
